regfile_snapshot: RTL and testbench
===================================

Name: regfile_snapshot

Overview:
Debug readout engine for the CPU register file. On request it walks all 16 general/segment registers through one regfile read port, then the packed flags word. It streams a framed, checksummed sequence of 16-bit words over a valid/ready interface to the debug host link (UART/JTAG bridge). It reads the register file; it never writes it. It runs while the core is halted by the debug controller.

Parameters:
HDR_WORD, 16'hA55A, first word of every frame
NREGS, 16, number of registers walked (rd_addr width fixed at 4 bits; NREGS <= 16)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  single-cycle request to begin a snapshot
abort  input  1  synchronous cancel of an in-progress snapshot
rd_addr  output  4  register address driven to a regfile read port (byte mode off)
rd_data  input  16  combinational read data for rd_addr
flags_in  input  16  packed flags word (regfile oflags output)
out_data  output  16  stream word
out_valid  output  1  stream word valid
out_ready  input  1  sink accepts word when out_valid & out_ready
busy  output  1  high from accepted start until frame end/abort
done  output  1  one-cycle pulse after checksum word accepted

Behaviour:
- Reset (async, rst=1): state IDLE; idx=0, sum=0, rd_addr=0, out_data=0, out_valid=0, busy=0, done=0.
- Frame = HDR_WORD, r[0]..r[NREGS-1], flags_in, checksum; 18 words for NREGS=16.
- checksum = 16-bit wrap-around sum of all data words (registers + flags), header excluded.
- rd_addr = idx[3:0] at all times, registered.
- States:
  - IDLE: busy=0. On start=1: out_data<=HDR_WORD, out_valid<=1, idx<=0, sum<=0, busy<=1, go to HDR.
  - HDR: hold word. On handshake: out_valid<=0, go to LOAD.
  - LOAD (exactly 1 cycle): word = (idx==NREGS) ? flags_in : rd_data. Then out_data<=word, sum<=sum+word, out_valid<=1, go to SEND.
  - SEND: hold out_data/out_valid/rd_addr while out_ready=0. On handshake:
    - if idx==NREGS: out_data<=sum, out_valid stays 1, go to SUM.
    - else: idx<=idx+1, out_valid<=0, go to LOAD.
  - SUM: on handshake: out_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
- Latency with out_ready held 1:
  - header valid 1 cycle after start;
  - each data word valid 2 cycles after the previous handshake (one LOAD bubble);
  - checksum valid the cycle after the flags handshake.
  - Full frame occupies 36 cycles for NREGS=16.
- out_data never changes while out_valid=1 and out_ready=0. out_valid never drops without a handshake except on abort/rst.
- start while busy=1 is ignored. start and abort in the same IDLE cycle: abort wins, no frame.
- abort=1 in any non-IDLE state: next cycle IDLE, out_valid=0, busy=0, idx=0, sum=0, done stays 0. A partial frame is left unterminated; the host resyncs on HDR_WORD.
- rst mid-frame: immediate return to reset values; no done.
- done and start in the same cycle: the new start is accepted (state is IDLE that cycle).

Test Plan:
- Regfile model r[i]=16'h1000+i, flags_in=16'h0202, out_ready=1, pulse start -> words A55A,1000..100F,0202,027A; done pulses once the cycle after 027A accepted; busy high 36 cycles.
- Backpressure: hold out_ready=0 for 5 cycles while out_data=1003 is valid -> out_data=1003, out_valid=1, rd_addr=3 stable throughout; sequence resumes with 1004 and the checksum is unchanged (027A).
- Random out_ready (50%) over 20 frames with random register contents -> every frame matches the reference model, including checksum wrap (e.g. all r=FFFF, flags=FFFF: checksum 16'hFFEF).
- start pulsed again during the r[7] word -> ignored; single frame of 18 words; done pulses once.
- abort asserted during the r[5] word -> next cycle out_valid=0, busy=0, no done; the following start yields a complete correct frame.
- rst asserted asynchronously mid-LOAD (between clock edges) -> out_valid, busy, done and rd_addr go 0 immediately; after release, IDLE awaits start.

Source files
------------

// File: rtl/regfile_snapshot.sv
// regfile_snapshot: debug readout engine for the CPU register file.
// Walks registers 0..NREGS-1 through a single regfile read port, appends the
// packed flags word and a 16-bit wrap-around checksum of those data words,
// and streams the frame HDR_WORD, r[0..NREGS-1], flags, checksum to the
// debug host link. The register file is only ever read.
//
// Stream handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. While out_valid=1 and out_ready=0 the word in
// out_data is held unchanged; out_valid only falls after a transfer, or when
// abort/rst cancels the frame.
module regfile_snapshot #(
   parameter logic [15:0] HDR_WORD = 16'hA55A,
   parameter int unsigned NREGS    = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic [3:0]  rd_addr,
   input  logic [15:0] rd_data,
   input  logic [15:0] flags_in,
   output logic [15:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic [2:0]  dbg_state_o
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_LOAD = 3'd2,
      ST_SEND = 3'd3,
      ST_SUM  = 3'd4
   } state_t;

   // idx runs 0..NREGS; the value NREGS selects the flags word.
   localparam logic [4:0] LAST_IDX = 5'(NREGS);

   state_t      state_q;
   logic [4:0]  idx_q;
   logic [3:0]  rd_addr_q;
   logic [15:0] sum_q;
   logic [15:0] out_data_q;
   logic        out_valid_q;
   logic        busy_q;
   logic        done_q;

   logic        xfer;
   logic        at_flags;
   logic [4:0]  idx_d;
   logic [15:0] word_d;
   logic [15:0] sum_d;

   // Word capture path: pick flags or regfile data and fold it into the sum.
   always_comb begin
      xfer     = out_valid_q & out_ready;
      at_flags = (idx_q == LAST_IDX);
      idx_d    = idx_q + 5'd1;
      word_d   = at_flags ? flags_in : rd_data;
      sum_d    = sum_q + word_d;
   end

   // Frame sequencer: state, address walk, running sum and stream outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         rd_addr_q   <= '0;
         sum_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort) begin
            // Cancel leaves the partial frame unterminated; the host resyncs
            // on the next header word. Also blocks a same-cycle start.
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rd_addr_q   <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     out_data_q  <= HDR_WORD;
                     out_valid_q <= 1'b1;
                     idx_q       <= '0;
                     rd_addr_q   <= '0;
                     sum_q       <= '0;
                     busy_q      <= 1'b1;
                     state_q     <= ST_HDR;
                  end
               end
               ST_HDR: begin
                  if (xfer) begin
                     out_valid_q <= 1'b0;
                     state_q     <= ST_LOAD;
                  end
               end
               ST_LOAD: begin
                  // rd_addr has been stable for a full cycle here, so the
                  // combinational regfile read is settled.
                  out_data_q  <= word_d;
                  sum_q       <= sum_d;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_SEND;
               end
               ST_SEND: begin
                  if (xfer) begin
                     if (at_flags) begin
                        out_data_q <= sum_q;
                        state_q    <= ST_SUM;
                     end else begin
                        idx_q       <= idx_d;
                        rd_addr_q   <= idx_d[3:0];
                        out_valid_q <= 1'b0;
                        state_q     <= ST_LOAD;
                     end
                  end
               end
               ST_SUM: begin
                  if (xfer) begin
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= ST_IDLE;
                  end
               end
               default: begin
                  state_q     <= ST_IDLE;
                  idx_q       <= '0;
                  rd_addr_q   <= '0;
                  sum_q       <= '0;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rd_addr     = rd_addr_q;
   assign out_data    = out_data_q;
   assign out_valid   = out_valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

`ifndef SYNTHESIS
   // A stalled word stays valid and unchanged until it transfers.
   a_hold_stable: assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready && !abort) |=> (out_valid && $stable(out_data)));

   // Stream words only exist inside a busy frame.
   a_valid_in_frame: assert property (@(posedge clk) disable iff (rst)
      !busy |-> !out_valid);

   // The completion pulse follows the last transfer, outside the frame.
   a_done_idle: assert property (@(posedge clk) disable iff (rst)
      done |-> (!busy && !out_valid));
`endif

endmodule

// File: tb/tb_regfile_snapshot.sv
// Bench for regfile_snapshot: table of whole-frame vectors with known
// checksums, hand sequences for backpressure, start-while-busy, abort,
// back-to-back frames and asynchronous reset, then random frames.
module tb_regfile_snapshot;

   localparam logic [15:0] HDR = 16'hA55A;
   localparam int NR = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        out_ready = 1'b0;
   logic [3:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] flags_in;
   logic [15:0] out_data;
   logic        out_valid;
   logic        busy;
   logic        done;
   logic [2:0]  dbg_state;

   logic [15:0] regs [NR];

   int n_tests   = 0;
   int n_fail    = 0;
   int ready_pct = 100;
   bit force_low = 1'b0;
   int done_cnt  = 0;
   int busy_cyc  = 0;
   bit done_exp  = 1'b0;

   // bit 16 marks the checksum word that closes a frame
   logic [16:0] exp_q [$];

   typedef struct {
      logic [15:0] base;
      logic [15:0] step;
      logic [15:0] flg;
      int          pct;
      logic [15:0] sum;
   } vec_t;
   vec_t vecs [6];

   regfile_snapshot dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .flags_in    (flags_in),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .done        (done),
      .dbg_state_o (dbg_state)
   );

   // Combinational register file read port
   assign rd_data = regs[rd_addr];

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sink ready driver
   always @(posedge clk) begin
      #1;
      if (force_low) out_ready = 1'b0;
      else out_ready = (int'($urandom_range(99)) < ready_pct);
   end

   // Scoreboard monitor: pops one expected word per transfer, checks done timing
   always @(negedge clk) begin
      if (rst) begin
         done_exp = 1'b0;
      end else begin
         if (done || done_exp) chk("done_pulse", done, done_exp);
         if (done) done_cnt++;
         done_exp = 1'b0;
         if (busy) busy_cyc++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_word: got %h expected no word (t=%0t)", out_data, $time);
            end else begin
               logic [16:0] e;
               e = exp_q.pop_front();
               chk("stream_word", out_data, e[15:0]);
               if (e[16]) done_exp = 1'b1;
            end
         end
      end
   end

   task automatic fill_lin(input logic [15:0] base, input logic [15:0] step);
      for (int i = 0; i < NR; i++) regs[i] = base + step * 16'(i);
   endtask

   task automatic push_words(input int n);
      exp_q.push_back({1'b0, HDR});
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, regs[i]});
   endtask

   task automatic push_frame(input logic [15:0] sum);
      push_words(NR);
      exp_q.push_back({1'b0, flags_in});
      exp_q.push_back({1'b1, sum});
   endtask

   function automatic logic [15:0] model_sum();
      logic [15:0] s;
      s = flags_in;
      for (int i = 0; i < NR; i++) s = s + regs[i];
      return s;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      busy_cyc = 0;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int target, input int max, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(name, (done_cnt >= target), 1);
      @(negedge clk);
   endtask

   task automatic wait_word(input logic [15:0] val, input int max, input string name);
      int n;
      n = 0;
      while (!(out_valid && out_data == val) && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(name, (out_valid && out_data == val), 1);
   endtask

   task automatic idle_check(input int cycles, input string name);
      int bad;
      bad = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (out_valid || busy || done) bad++;
      end
      chk(name, bad, 0);
   endtask

   task automatic run_vec(input int v);
      int base;
      fill_lin(vecs[v].base, vecs[v].step);
      flags_in  = vecs[v].flg;
      ready_pct = vecs[v].pct;
      base = done_cnt;
      push_frame(vecs[v].sum);
      pulse_start();
      chk("hdr_latency", {busy, out_valid}, 2'b11);
      wait_done(base + 1, 400, "frame_done");
      chk("done_count", done_cnt, base + 1);
      chk("queue_empty", exp_q.size(), 0);
      if (vecs[v].pct == 100) chk("busy_cycles", busy_cyc, 36);
   endtask

   initial begin
      int base;
      int n;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      flags_in = 16'h0;
      fill_lin(16'h0, 16'h0);

      vecs[0] = '{16'h1000, 16'h0001, 16'h0202, 100, 16'h027A};
      vecs[1] = '{16'hFFFF, 16'h0000, 16'hFFFF,  50, 16'hFFEF};
      vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 100, 16'h0000};
      vecs[3] = '{16'h8000, 16'h0000, 16'h0001,  70, 16'h0001};
      vecs[4] = '{16'h0000, 16'h0001, 16'h1234, 100, 16'h12AC};
      vecs[5] = '{16'h0F00, 16'h0100, 16'h9800, 100, 16'h0000};

      // reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_state", dbg_state, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // table-driven frames
      for (int v = 0; v < 6; v++) run_vec(v);

      // backpressure on r[3]
      fill_lin(16'h1000, 16'h0001);
      flags_in = 16'h0202;
      ready_pct = 100;
      base = done_cnt;
      push_frame(16'h027A);
      pulse_start();
      wait_word(16'h1002, 50, "bp_reach_1002");
      force_low = 1'b1;
      wait_word(16'h1003, 10, "bp_reach_1003");
      for (int k = 0; k < 5; k++) begin
         chk("bp_data", out_data, 16'h1003);
         chk("bp_valid", out_valid, 1);
         chk("bp_rd_addr", rd_addr, 4'd3);
         @(negedge clk);
      end
      force_low = 1'b0;
      wait_done(base + 1, 400, "bp_done");
      chk("bp_done_count", done_cnt, base + 1);
      chk("bp_queue_empty", exp_q.size(), 0);

      // start while busy is ignored
      base = done_cnt;
      push_frame(16'h027A);
      pulse_start();
      wait_word(16'h1007, 50, "sb_reach_1007");
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(base + 1, 400, "sb_done");
      idle_check(10, "sb_no_second_frame");
      chk("sb_done_count", done_cnt, base + 1);
      chk("sb_queue_empty", exp_q.size(), 0);

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("sa_busy", busy, 0);
      chk("sa_valid", out_valid, 0);
      idle_check(4, "sa_stays_idle");

      // abort while r[5] is stalled
      base = done_cnt;
      push_words(5);
      pulse_start();
      wait_word(16'h1004, 50, "ab_reach_1004");
      force_low = 1'b1;
      wait_word(16'h1005, 10, "ab_reach_1005");
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_valid", out_valid, 0);
      chk("ab_busy", busy, 0);
      chk("ab_rd_addr", rd_addr, 0);
      chk("ab_done", done, 0);
      chk("ab_queue_empty", exp_q.size(), 0);
      force_low = 1'b0;
      idle_check(6, "ab_stays_idle");
      chk("ab_no_done", done_cnt, base);
      run_vec(0);

      // done and start in the same cycle: back-to-back frames
      fill_lin(16'h2000, 16'h0003);
      flags_in = 16'h5555;
      ready_pct = 100;
      base = done_cnt;
      push_frame(model_sum());
      push_frame(model_sum());
      pulse_start();
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_done_seen", done, 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_restart", {busy, out_valid}, 2'b11);
      wait_done(base + 2, 400, "b2b_done");
      chk("b2b_done_count", done_cnt, base + 2);
      chk("b2b_queue_empty", exp_q.size(), 0);

      // asynchronous reset in the middle of LOAD for r[3]
      fill_lin(16'h1000, 16'h0001);
      flags_in = 16'h0202;
      push_words(3);
      pulse_start();
      n = 0;
      while (!(busy && !out_valid && rd_addr == 4'd3) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rs_reach_load3", (busy && !out_valid && rd_addr == 4'd3), 1);
      #2 rst = 1'b1;
      #1;
      chk("rs_valid", out_valid, 0);
      chk("rs_busy", busy, 0);
      chk("rs_done", done, 0);
      chk("rs_rd_addr", rd_addr, 0);
      chk("rs_out_data", out_data, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("rs_queue_empty", exp_q.size(), 0);
      idle_check(5, "rs_idle_after_release");

      // random contents with random backpressure
      ready_pct = 50;
      for (int f = 0; f < 20; f++) begin
         for (int i = 0; i < NR; i++) regs[i] = 16'($urandom);
         flags_in = 16'($urandom);
         base = done_cnt;
         push_frame(model_sum());
         pulse_start();
         wait_done(base + 1, 600, "rnd_done");
         chk("rnd_done_count", done_cnt, base + 1);
         chk("rnd_queue_empty", exp_q.size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Time limit
   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation still running at t=%0t", $time);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "time limit reached");
   end

endmodule
